// File: rtl/parking_capacity_manager.sv
// Two-class (reserved/public) parking occupancy tracker with an internal
// time-of-day clock and an hourly reserved->public capacity schedule.
module parking_capacity_manager #(
  parameter int CNT_W          = 10,
  parameter int TOTAL_CAP      = 700,
  parameter int RSV_CAP_INIT   = 500,
  parameter int RSV_MIN        = 200,
  parameter int RELEASE_STEP   = 50,
  parameter int RELEASE_START  = 14,
  parameter int RELEASE_END    = 15,
  parameter int RESTORE_HOUR   = 16,
  parameter int TICKS_PER_HOUR = 60,
  parameter int START_HOUR     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             entry_rsv,
  input  logic             exit_req,
  input  logic             exit_rsv,
  output logic             entry_grant,
  output logic             entry_deny,
  output logic             exit_ack,
  output logic             exit_err,
  output logic [CNT_W-1:0] rsv_parked,
  output logic [CNT_W-1:0] pub_parked,
  output logic [CNT_W-1:0] rsv_cap,
  output logic [CNT_W-1:0] pub_cap,
  output logic [CNT_W-1:0] rsv_free,
  output logic [CNT_W-1:0] pub_free,
  output logic             rsv_avail,
  output logic             pub_avail,
  output logic [4:0]       hour,
  output logic [7:0]       day
);

  localparam int TICK_W = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_HOUR - 1);
  localparam logic [CNT_W-1:0]  TOTAL     = CNT_W'(TOTAL_CAP);
  localparam logic [CNT_W-1:0]  RSV_INIT  = CNT_W'(RSV_CAP_INIT);
  localparam logic [CNT_W-1:0]  RSV_LOW   = CNT_W'(RSV_MIN);
  localparam logic [CNT_W-1:0]  STEP      = CNT_W'(RELEASE_STEP);
  localparam logic [CNT_W-1:0]  PUB_INIT  = CNT_W'(TOTAL_CAP - RSV_CAP_INIT);

  // Class index 1 = reserved, 0 = public.
  logic [CNT_W-1:0] parked_q [2];
  logic [CNT_W-1:0] parked_d [2];
  logic [CNT_W-1:0] cap_q    [2];
  logic [CNT_W-1:0] cap_d    [2];
  logic [CNT_W-1:0] free_c   [2];
  logic [1:0]       inc;
  logic [1:0]       dec;

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [4:0]        hour_q, hour_d, hour_next;
  logic [7:0]        day_q, day_d;
  logic              hour_tick;

  logic entry_grant_q, entry_grant_d;
  logic entry_deny_q, entry_deny_d;
  logic exit_ack_q, exit_ack_d;
  logic exit_err_q, exit_err_d;

  logic [CNT_W-1:0] rsv_free_post;
  logic [CNT_W-1:0] release_amt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] clamp_lo;
  logic [CNT_W-1:0] clamp_hi;
  logic [CNT_W-1:0] clamped;

  // Entry/exit decisions are taken on pre-edge registers, so a full class can
  // still release a car and an empty class can still admit one in one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_class
      assign free_c[gi]   = cap_q[gi] - parked_q[gi];
      assign inc[gi]      = entry_req && (entry_rsv == 1'(gi)) && (free_c[gi] != '0);
      assign dec[gi]      = exit_req && (exit_rsv == 1'(gi)) && (parked_q[gi] != '0);
      assign parked_d[gi] = parked_q[gi] + CNT_W'(inc[gi]) - CNT_W'(dec[gi]);
    end
  endgenerate

  always_comb begin
    entry_grant_d = |inc;
    entry_deny_d  = entry_req && !(|inc);
    exit_ack_d    = |dec;
    exit_err_d    = exit_req && !(|dec);
  end

  always_comb begin
    hour_tick = (tick_q == TICK_LAST);
    tick_d    = hour_tick ? '0 : tick_q + TICK_W'(1);
    hour_next = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    hour_d    = hour_tick ? hour_next : hour_q;
    day_d     = (hour_tick && (hour_q == 5'd23)) ? day_q + 8'd1 : day_q;
  end

  // Rebalance works on post-event occupancy; min/clamp compare before
  // subtracting so nothing wraps.
  always_comb begin
    rsv_free_post = cap_q[1] - parked_d[1];
    release_amt   = (rsv_free_post < STEP) ? rsv_free_post : STEP;
    target        = cap_q[1];
    if ((hour_next >= 5'(RELEASE_START)) && (hour_next <= 5'(RELEASE_END))) begin
      target = cap_q[1] - release_amt;
    end else if (hour_next == 5'(RESTORE_HOUR)) begin
      target = RSV_LOW;
    end else if (hour_next == 5'd0) begin
      target = RSV_INIT;
    end
    clamp_lo = parked_d[1];
    clamp_hi = TOTAL - parked_d[0];
    if (target < clamp_lo) begin
      clamped = clamp_lo;
    end else if (target > clamp_hi) begin
      clamped = clamp_hi;
    end else begin
      clamped = target;
    end
    cap_d[1] = hour_tick ? clamped : cap_q[1];
    cap_d[0] = TOTAL - cap_d[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parked_q[0]   <= '0;
      parked_q[1]   <= '0;
      cap_q[1]      <= RSV_INIT;
      cap_q[0]      <= PUB_INIT;
      tick_q        <= '0;
      hour_q        <= 5'(START_HOUR);
      day_q         <= '0;
      entry_grant_q <= 1'b0;
      entry_deny_q  <= 1'b0;
      exit_ack_q    <= 1'b0;
      exit_err_q    <= 1'b0;
    end else begin
      parked_q[0]   <= parked_d[0];
      parked_q[1]   <= parked_d[1];
      cap_q[0]      <= cap_d[0];
      cap_q[1]      <= cap_d[1];
      tick_q        <= tick_d;
      hour_q        <= hour_d;
      day_q         <= day_d;
      entry_grant_q <= entry_grant_d;
      entry_deny_q  <= entry_deny_d;
      exit_ack_q    <= exit_ack_d;
      exit_err_q    <= exit_err_d;
    end
  end

  assign entry_grant = entry_grant_q;
  assign entry_deny  = entry_deny_q;
  assign exit_ack    = exit_ack_q;
  assign exit_err    = exit_err_q;
  assign rsv_parked  = parked_q[1];
  assign pub_parked  = parked_q[0];
  assign rsv_cap     = cap_q[1];
  assign pub_cap     = cap_q[0];
  assign rsv_free    = free_c[1];
  assign pub_free    = free_c[0];
  assign rsv_avail   = (free_c[1] != '0);
  assign pub_avail   = (free_c[0] != '0);
  assign hour        = hour_q;
  assign day         = day_q;

endmodule

// File: doc/parking_capacity_manager.md
Name: parking_capacity_manager

Overview:
- Parametrised successor of the two-class (reserved/public) parking controller.
- Tracks occupancy for both classes and runs an internal time-of-day clock.
- Shifts capacity between classes on a configurable hourly schedule.
- Handles an entry and an exit in the same cycle, with registered grant/deny/ack/error responses. Sits between gate sensors and the display/barrier logic.

Parameters:
- CNT_W, 10, width of all occupancy/capacity counts; must hold TOTAL_CAP
- TOTAL_CAP, 700, combined spaces, constant
- RSV_CAP_INIT, 500, reserved capacity after reset and at midnight
- RSV_MIN, 200, reserved capacity target at RESTORE_HOUR
- RELEASE_STEP, 50, max spaces moved reserved->public per release hour
- RELEASE_START, 14, first release hour (inclusive)
- RELEASE_END, 15, last release hour (inclusive)
- RESTORE_HOUR, 16, hour of the RSV_MIN rebalance
- TICKS_PER_HOUR, 60, clk cycles per hour
- START_HOUR, 8, hour after reset (0..23)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- entry_req  in  1  one car requesting entry this cycle
- entry_rsv  in  1  entering car is reserved class (1) or public (0)
- exit_req  in  1  one car leaving this cycle
- exit_rsv  in  1  leaving car is reserved class (1) or public (0)
- entry_grant  out  1  registered pulse, entry accepted
- entry_deny  out  1  registered pulse, class full
- exit_ack  out  1  registered pulse, exit accepted
- exit_err  out  1  registered pulse, exit with zero parked in class
- rsv_parked, pub_parked  out  CNT_W  registered occupancy
- rsv_cap, pub_cap  out  CNT_W  registered capacity; sum always TOTAL_CAP
- rsv_free, pub_free  out  CNT_W  cap - parked, combinational from registers
- rsv_avail, pub_avail  out  1  free != 0
- hour  out  5  0..23
- day  out  8  day count, wraps 255->0

Behaviour:
Reset (async, any time, including mid-operation):
- Parked counts 0; rsv_cap = RSV_CAP_INIT; pub_cap = TOTAL_CAP - RSV_CAP_INIT.
- hour = START_HOUR; day = 0; tick counter 0; all response pulses 0.

Time:
- Tick counter counts 0..TICKS_PER_HOUR-1; hour_tick is asserted when it equals TICKS_PER_HOUR-1, then the counter returns to 0.
- On hour_tick, hour advances mod 24. On 23->0, day increments.

Car events, every cycle, both may occur together:
- Entry is granted iff the selected class free count is nonzero, evaluated on pre-edge registers. On grant, that class's parked count increments. Otherwise entry_deny.
- Exit is acked iff the selected class parked count is nonzero, evaluated on pre-edge registers. On ack, that class's parked count decrements. Otherwise exit_err.
- Same class entry+exit when full: entry denied, exit acked, net parked -1.
- Same class entry+exit with parked 0: exit_err, entry granted, net +1.
- Pulses are asserted exactly one cycle after the sampling edge, i.e. in the same cycle the counts reflect the event.
- Held entry_req means one car per cycle.

Rebalance, only on hour_tick cycles, using the new hour:
- Computed after the same-cycle car events, on the updated parked counts.
- Target selection:
  - new hour in [RELEASE_START, RELEASE_END]: target = rsv_cap - min(rsv_free_post, RELEASE_STEP).
  - new hour == RESTORE_HOUR: target = RSV_MIN.
  - new hour == 0: target = RSV_CAP_INIT.
  - any other hour: no change.
- rsv_cap = clamp(target, rsv_parked, TOTAL_CAP - pub_parked); pub_cap = TOTAL_CAP - rsv_cap.
- Invariants: parked <= cap per class and rsv_parked + pub_parked <= TOTAL_CAP, so the clamp range is never empty.
- No free count ever underflows.

Arithmetic:
- All unsigned in CNT_W bits.
- min/clamp are compared before subtracting, so no intermediate wrap.

Test Plan:
All scenarios use TICKS_PER_HOUR=4 and other defaults.
1. Reset: assert rst mid-run -> parked 0/0, rsv_cap 500, pub_cap 200, hour 8, day 0, pulses 0, immediately (async).
2. Fill public: 200 entry_req with entry_rsv=0 -> 200 grants, pub_free 0, pub_avail 0. 201st -> entry_deny, pub_parked stays 200.
3. Full public, entry_req+exit_req both public in one cycle -> entry_deny and exit_ack, pub_parked 199. Same stimulus with reserved parked 0 -> exit_err with entry_grant, rsv_parked 1.
4. Release: rsv_parked 420, pub_parked 0. Tick to hour 14 -> rsv_cap 450, pub_cap 250. Hour 15 -> 420/280. Hour 16 -> target 200 clamped to 420.
5. Restore/midnight: rsv_parked 100, pub_parked 0. Hour 16 -> rsv_cap 200, pub_cap 500. Fill pub_parked to 450, advance to hour 0 -> rsv_cap 250, pub_cap 450, day 1.
6. Car event on a tick cycle: rsv_parked 420 and a reserved entry at the 13->14 tick -> rsv_parked 421, rsv_cap 450, rsv_free 29.
